// File: rtl/pc_ir_unit_if.sv
// Control/data bundle between the control unit, memory and the fetch stage.
// The master side drives the controls and operands; the slave side is pc_ir_unit.
interface pc_ir_unit_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) ();
    logic              il_in;
    logic [1:0]        ps_in;
    logic              mm_in;
    logic [DATA_W-1:0] bus_a_in;
    logic [DATA_W-1:0] mem_data_in;
    logic              cnt_clr_in;
    logic [DATA_W-1:0] ins_out;
    logic [ADDR_W-1:0] pc_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic [CNT_W-1:0]  fetch_cnt_out;

    modport master (
        output il_in, ps_in, mm_in, bus_a_in, mem_data_in, cnt_clr_in,
        input  ins_out, pc_out, mem_addr_out, fetch_cnt_out
    );

    modport slave (
        input  il_in, ps_in, mm_in, bus_a_in, mem_data_in, cnt_clr_in,
        output ins_out, pc_out, mem_addr_out, fetch_cnt_out
    );
endinterface

// File: rtl/pc_ir_unit.sv
// Instruction-fetch stage: program counter, instruction register, memory address mux
// and a saturating count of instruction-register loads.
module pc_ir_unit #(
    parameter int                DATA_W = 16,
    parameter int                ADDR_W = 16,
    parameter logic [ADDR_W-1:0] RST_PC = {ADDR_W{1'b0}},
    parameter int                CNT_W  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    pc_ir_unit_if.slave     bus
);

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_REL  = 2'b10;
    localparam logic [1:0] PS_JMP  = 2'b11;

    localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] ir_r;
    logic [ADDR_W-1:0] pc_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [ADDR_W-1:0] pc_next_s;
    logic [ADDR_W-1:0] mem_addr_s;

    // The branch offset is split across IR[8:6] and IR[2:0]; sign-extend it to PC width.
    function automatic logic [ADDR_W-1:0] branch_offset(input logic [5:0] off);
        return {{(ADDR_W-6){off[5]}}, off};
    endfunction

    // Next-PC selection; the relative offset always comes from the IR held before this edge.
    always_comb begin
        pc_next_s = pc_r;
        case (bus.ps_in)
            PS_HOLD: pc_next_s = pc_r;
            PS_INC:  pc_next_s = pc_r + PC_ONE;
            PS_REL:  pc_next_s = pc_r + branch_offset({ir_r[8:6], ir_r[2:0]});
            PS_JMP:  pc_next_s = bus.bus_a_in[ADDR_W-1:0];
            default: pc_next_s = pc_r;
        endcase
    end

    // Memory address mux stays live through reset so memory can be driven from bus A at any time.
    always_comb begin
        mem_addr_s = pc_r;
        if (bus.mm_in) begin
            mem_addr_s = pc_r;
        end else begin
            mem_addr_s = bus.bus_a_in[ADDR_W-1:0];
        end
    end

    // Program counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= RST_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // Instruction register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_r <= {DATA_W{1'b0}};
        end else if (bus.il_in) begin
            ir_r <= bus.mem_data_in;
        end else begin
            ir_r <= ir_r;
        end
    end

    // Saturating fetch counter; a clear wins over a simultaneous load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (bus.cnt_clr_in) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (bus.il_in && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bus.ins_out       = ir_r;
    assign bus.pc_out        = pc_r;
    assign bus.fetch_cnt_out = cnt_r;
    assign bus.mem_addr_out  = mem_addr_s;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Directed bench for pc_ir_unit: a vector table for fetch/branch/jump/mux/counter behaviour,
// plus sequences for reset, counter saturation on a narrow-counter instance and mid-run reset.
module tb_pc_ir_unit;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    pc_ir_unit_if #(.DATA_W(16), .ADDR_W(16), .CNT_W(16)) bus ();
    pc_ir_unit_if #(.DATA_W(16), .ADDR_W(16), .CNT_W(4))  bus4 ();

    pc_ir_unit #(.DATA_W(16), .ADDR_W(16), .RST_PC(16'h0000), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    pc_ir_unit #(.DATA_W(16), .ADDR_W(16), .RST_PC(16'h0100), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        il;
        logic [1:0]  ps;
        logic        mm;
        logic        clr;
        logic [15:0] bus_a;
        logic [15:0] mem;
        logic [15:0] e_ins;
        logic [15:0] e_pc;
        logic [15:0] e_addr;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(input logic il, input logic [1:0] ps, input logic mm,
                                input logic clr, input logic [15:0] bus_a, input logic [15:0] mem,
                                input logic [15:0] e_ins, input logic [15:0] e_pc,
                                input logic [15:0] e_addr, input logic [15:0] e_cnt);
        vec_t v;
        v.il = il; v.ps = ps; v.mm = mm; v.clr = clr; v.bus_a = bus_a; v.mem = mem;
        v.e_ins = e_ins; v.e_pc = e_pc; v.e_addr = e_addr; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic il, input logic [1:0] ps, input logic mm, input logic clr,
                         input logic [15:0] bus_a, input logic [15:0] mem);
        bus.il_in = il; bus.ps_in = ps; bus.mm_in = mm; bus.cnt_clr_in = clr;
        bus.bus_a_in = bus_a; bus.mem_data_in = mem;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        //            il    ps     mm    clr   bus_a     mem       ins       pc        addr      cnt
        vecs[0]  = mk(1'b1, 2'd0, 1'b1, 1'b0, 16'h5555, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 16'd1);
        vecs[1]  = mk(1'b0, 2'd1, 1'b1, 1'b0, 16'h5555, 16'h9999, 16'h1234, 16'h0001, 16'h0001, 16'd1);
        vecs[2]  = mk(1'b1, 2'd0, 1'b1, 1'b0, 16'h0000, 16'h01C5, 16'h01C5, 16'h0001, 16'h0001, 16'd2);
        vecs[3]  = mk(1'b0, 2'd3, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h01C5, 16'h0010, 16'h0010, 16'd2);
        vecs[4]  = mk(1'b0, 2'd2, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h01C5, 16'h000D, 16'h000D, 16'd2);
        vecs[5]  = mk(1'b0, 2'd3, 1'b1, 1'b0, 16'hFFFE, 16'h0000, 16'h01C5, 16'hFFFE, 16'hFFFE, 16'd2);
        vecs[6]  = mk(1'b1, 2'd0, 1'b1, 1'b0, 16'h0000, 16'h0005, 16'h0005, 16'hFFFE, 16'hFFFE, 16'd3);
        vecs[7]  = mk(1'b0, 2'd2, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0005, 16'h0003, 16'h0003, 16'd3);
        vecs[8]  = mk(1'b0, 2'd3, 1'b1, 1'b0, 16'hBEEF, 16'h0000, 16'h0005, 16'hBEEF, 16'hBEEF, 16'd3);
        vecs[9]  = mk(1'b0, 2'd0, 1'b0, 1'b0, 16'h0042, 16'h0000, 16'h0005, 16'hBEEF, 16'h0042, 16'd3);
        vecs[10] = mk(1'b0, 2'd3, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0005, 16'hFFFF, 16'hFFFF, 16'd3);
        vecs[11] = mk(1'b0, 2'd1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 16'd3);
        vecs[12] = mk(1'b1, 2'd2, 1'b1, 1'b0, 16'h0000, 16'h0003, 16'h0003, 16'h0005, 16'h0005, 16'd4);
        vecs[13] = mk(1'b0, 2'd2, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0003, 16'h0008, 16'h0008, 16'd4);
        vecs[14] = mk(1'b1, 2'd0, 1'b1, 1'b1, 16'h0000, 16'h00AA, 16'h00AA, 16'h0008, 16'h0008, 16'd0);
        vecs[15] = mk(1'b1, 2'd0, 1'b1, 1'b0, 16'h0000, 16'h0077, 16'h0077, 16'h0008, 16'h0008, 16'd1);
        vecs[16] = mk(1'b0, 2'd0, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0077, 16'h0008, 16'h0008, 16'd0);
        vecs[17] = mk(1'b1, 2'd0, 1'b1, 1'b0, 16'h0000, 16'h0100, 16'h0100, 16'h0008, 16'h0008, 16'd1);
        vecs[18] = mk(1'b0, 2'd2, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0100, 16'hFFE8, 16'hFFE8, 16'd1);
        vecs[19] = mk(1'b1, 2'd0, 1'b1, 1'b0, 16'h0000, 16'h00C7, 16'h00C7, 16'hFFE8, 16'hFFE8, 16'd2);
        vecs[20] = mk(1'b0, 2'd2, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h00C7, 16'h0007, 16'h0007, 16'd2);
        vecs[21] = mk(1'b1, 2'd0, 1'b1, 1'b0, 16'h0000, 16'hF638, 16'hF638, 16'h0007, 16'h0007, 16'd3);
        vecs[22] = mk(1'b0, 2'd2, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hF638, 16'h0007, 16'h0007, 16'd3);

        rst_n = 1'b0;
        drive(1'b0, 2'd0, 1'b1, 1'b0, 16'h0000, 16'h0000);
        bus4.il_in = 1'b0; bus4.ps_in = 2'd0; bus4.mm_in = 1'b1; bus4.cnt_clr_in = 1'b0;
        bus4.bus_a_in = 16'h0000; bus4.mem_data_in = 16'h0000;

        // Reset state, and the address mux staying live during reset
        #12;
        chk("rst_pc",   32'(bus.pc_out),         32'h0000);
        chk("rst_ins",  32'(bus.ins_out),        32'h0000);
        chk("rst_addr", 32'(bus.mem_addr_out),   32'h0000);
        chk("rst_cnt",  32'(bus.fetch_cnt_out),  32'h0000);
        chk("rst_pc4",  32'(bus4.pc_out),        32'h0100);
        chk("rst_addr4", 32'(bus4.mem_addr_out), 32'h0100);
        bus.mm_in = 1'b0; bus.bus_a_in = 16'h1357;
        #1;
        chk("rst_mux_bus_a", 32'(bus.mem_addr_out), 32'h1357);
        bus.mm_in = 1'b1; bus.bus_a_in = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive(vecs[i].il, vecs[i].ps, vecs[i].mm, vecs[i].clr, vecs[i].bus_a, vecs[i].mem);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ins", i),  32'(bus.ins_out),       32'(vecs[i].e_ins));
            chk($sformatf("v%0d_pc", i),   32'(bus.pc_out),        32'(vecs[i].e_pc));
            chk($sformatf("v%0d_addr", i), 32'(bus.mem_addr_out),  32'(vecs[i].e_addr));
            chk($sformatf("v%0d_cnt", i),  32'(bus.fetch_cnt_out), 32'(vecs[i].e_cnt));
        end

        // 4-bit counter saturates at 15 after 20 loads
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus4.il_in = 1'b1;
            bus4.mem_data_in = 16'(i);
            @(posedge clk);
            #1;
            if (i == 13) chk("sat_cnt_14", 32'(bus4.fetch_cnt_out), 32'd14);
        end
        chk("sat_cnt_15", 32'(bus4.fetch_cnt_out), 32'd15);
        chk("sat_ins",    32'(bus4.ins_out),       32'h0013);
        chk("sat_pc",     32'(bus4.pc_out),        32'h0100);
        @(negedge clk);
        bus4.cnt_clr_in = 1'b1;
        @(posedge clk);
        #1;
        chk("sat_clr", 32'(bus4.fetch_cnt_out), 32'd0);
        @(negedge clk);
        bus4.cnt_clr_in = 1'b0;
        bus4.il_in = 1'b1;
        @(posedge clk);
        #1;
        bus4.il_in = 1'b0;
        chk("sat_after_clr", 32'(bus4.fetch_cnt_out), 32'd1);

        // Reset between edges clears state at once and holds it across an edge
        @(negedge clk);
        drive(1'b1, 2'd1, 1'b1, 1'b0, 16'h0000, 16'hDEAD);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pc",   32'(bus.pc_out),        32'h0000);
        chk("mid_rst_ins",  32'(bus.ins_out),       32'h0000);
        chk("mid_rst_cnt",  32'(bus.fetch_cnt_out), 32'h0000);
        chk("mid_rst_pc4",  32'(bus4.pc_out),       32'h0100);
        chk("mid_rst_cnt4", 32'(bus4.fetch_cnt_out), 32'h0000);
        @(posedge clk);
        #1;
        chk("mid_rst_hold_pc",  32'(bus.pc_out),  32'h0000);
        chk("mid_rst_hold_ins", 32'(bus.ins_out), 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 2'd1, 1'b1, 1'b0, 16'h0000, 16'h0000);
        @(posedge clk);
        #1;
        chk("post_rst_inc", 32'(bus.pc_out), 32'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
